// File: rtl/secure_sib_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | secure_sib_ctrl: key-protected segment insertion bit for IJTAG.          |
// | Optional lockout after repeated failures: SECURE_SIB_LOCKOUT_EN.       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module secure_sib_ctrl #(
  parameter int                 KEY_W    = 8,
  parameter logic [KEY_W-1:0]   KEY      = 8'hA5,
  parameter int                 CNT_W    = 3,
  parameter int                 MAX_FAIL = 3
) (
  input  logic             CLK,
  input  logic             RstBar,
  input  logic             SelIn,
  input  logic             CaptureEn,
  input  logic             ShiftEn,
  input  logic             UpdateEn,
  input  logic             SI,
  output logic             SO,
  output logic             ToSI,
  input  logic             FromSO,
  output logic             SegSel,
  output logic             Locked,
  output logic [CNT_W-1:0] FailCnt
);

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    OPEN   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KEY_W:0]   scan_reg_q, scan_reg_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] fail_inc;
  logic             req;
  logic             key_ok;

  assign req      = scan_reg_q[KEY_W];
  assign key_ok   = (scan_reg_q[KEY_W-1:0] == KEY);
  assign fail_inc = fail_cnt_q + CNT_W'(1);

  always_comb begin
    scan_reg_d = scan_reg_q;
    if (SelIn) begin
      if (CaptureEn) begin
        // The key field is blanked so a secret can never be read back.
        scan_reg_d = {SegSel, {KEY_W{1'b0}}};
      end else if (ShiftEn) begin
        scan_reg_d = {SI, scan_reg_q[KEY_W:1]};
      end
    end
  end

  // Update decodes the register contents from before this edge.
  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    if (SelIn && UpdateEn) begin
      case (state_q)
        CLOSED, OPEN: begin
          if (!req) begin
            state_d = CLOSED;
          end else if (key_ok) begin
            state_d    = OPEN;
            fail_cnt_d = '0;
          end else begin
            state_d = CLOSED;
`ifdef SECURE_SIB_LOCKOUT_EN
            fail_cnt_d = fail_inc;
            if (fail_inc == CNT_W'(MAX_FAIL)) begin
              state_d = LOCKED;
            end
`else
            if (fail_cnt_q != {CNT_W{1'b1}}) begin
              fail_cnt_d = fail_inc;
            end
`endif
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RstBar) begin
    if (!RstBar) begin
      state_q    <= CLOSED;
      scan_reg_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      scan_reg_q <= scan_reg_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign SegSel  = (state_q == OPEN);
`ifdef SECURE_SIB_LOCKOUT_EN
  assign Locked  = (state_q == LOCKED);
`else
  assign Locked  = 1'b0;
`endif
  assign FailCnt = fail_cnt_q;
  assign ToSI    = scan_reg_q[0];
  assign SO      = SegSel ? FromSO : scan_reg_q[0];

endmodule
`default_nettype wire

// File: tb/tb_secure_sib_ctrl.sv
`default_nettype none
// Scoreboard bench for secure_sib_ctrl: randomized scan operations against a
// behavioural model of the unlock/lockout rules.
module tb_secure_sib_ctrl;

  logic       clk = 1'b0;
  logic       rst_bar, sel_in, capture_en, shift_en, update_en, si, from_so;
  logic       so, to_si, seg_sel, locked;
  logic [2:0] fail_cnt;

  always #5 clk = ~clk;

  secure_sib_ctrl #(.KEY_W(8), .KEY(8'hA5), .CNT_W(3), .MAX_FAIL(3)) dut (
    .CLK(clk), .RstBar(rst_bar), .SelIn(sel_in), .CaptureEn(capture_en),
    .ShiftEn(shift_en), .UpdateEn(update_en), .SI(si), .SO(so), .ToSI(to_si),
    .FromSO(from_so), .SegSel(seg_sel), .Locked(locked), .FailCnt(fail_cnt)
  );

  typedef struct packed {
    logic       seg;
    logic       lck;
    logic [2:0] fc;
    logic       tosi;
    logic       so;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: a 9-bit word, an "is open" flag, a lock flag, a count.
  logic [8:0] m_scan;
  bit         m_open, m_locked;
  int         m_fail;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_scan = '0; m_open = 0; m_locked = 0; m_fail = 0;
  endfunction

  function automatic void model_step(input bit sel, cap, sh, upd, s);
    logic [8:0] pre;
    pre = m_scan;
    if (sel && cap)      m_scan = {m_open, 8'h00};
    else if (sel && sh)  m_scan = {s, m_scan[8:1]};
    if (sel && upd && !m_locked) begin
      if (!pre[8]) begin
        m_open = 0;
      end else if (pre[7:0] == 8'hA5) begin
        m_open = 1; m_fail = 0;
      end else begin
        m_open = 0;
`ifdef SECURE_SIB_LOCKOUT_EN
        m_fail = m_fail + 1;
        if (m_fail == 3) m_locked = 1;
`else
        if (m_fail < 7) m_fail = m_fail + 1;
`endif
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.seg  = m_open;
    e.lck  = m_locked;
    e.fc   = 3'(m_fail);
    e.tosi = m_scan[0];
    e.so   = m_open ? from_so : m_scan[0];
    return e;
  endfunction

  // Monitor: compares every expectation queued during this clock cycle.
  always @(posedge clk) begin
    exp_t e;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      cmp("SegSel",  {7'd0, seg_sel}, {7'd0, e.seg});
      cmp("Locked",  {7'd0, locked},  {7'd0, e.lck});
      cmp("FailCnt", {5'd0, fail_cnt}, {5'd0, e.fc});
      cmp("ToSI",    {7'd0, to_si},   {7'd0, e.tosi});
      cmp("SO",      {7'd0, so},      {7'd0, e.so});
    end
  end

  task automatic op(input bit sel, cap, sh, upd, s);
    @(negedge clk);
    sel_in = sel; capture_en = cap; shift_en = sh; update_en = upd; si = s;
    from_so = 1'($urandom);
    @(posedge clk);
    #1;
    model_step(sel, cap, sh, upd, s);
    q.push_back(model_out());
  endtask

  task automatic shift_word(input logic [8:0] w);
    for (int i = 0; i < 9; i++) op(1, 0, 1, 0, w[i]);
  endtask

  task automatic shift_update(input logic [8:0] w);
    shift_word(w);
    op(1, 0, 0, 1, 0);
  endtask

  // Reset is applied between clock edges to show it acts asynchronously.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_bar = 0; sel_in = 0; capture_en = 0; shift_en = 0; update_en = 0;
    #1;
    model_reset();
    cmp("rst_SegSel",  {7'd0, seg_sel},  8'd0);
    cmp("rst_Locked",  {7'd0, locked},   8'd0);
    cmp("rst_FailCnt", {5'd0, fail_cnt}, 8'd0);
    cmp("rst_ToSI",    {7'd0, to_si},    8'd0);
    @(negedge clk);
    rst_bar = 1;
  endtask

  function automatic logic [8:0] pick_word();
    case ($urandom_range(0, 3))
      0:       return 9'h1A5;
      1:       return 9'h15A;
      2:       return {1'b0, 8'($urandom)};
      default: return 9'($urandom);
    endcase
  endfunction

  initial begin
    rst_bar = 1; sel_in = 0; capture_en = 0; shift_en = 0; update_en = 0;
    si = 0; from_so = 0;
    model_reset();
    do_reset();

    // Reset state read through a capture.
    op(1, 1, 0, 0, 0);
    // Correct key opens; capture then returns 9'h100, shifted out below.
    shift_update(9'h1A5);
    op(1, 1, 0, 0, 0);
    shift_word(9'($urandom));
    // Request bit clear closes without touching the count.
    shift_update({1'b0, 8'($urandom)});

    // Repeated bad keys, then a good key.
    for (int i = 0; i < 8; i++) shift_update(9'h15A);
    shift_update(9'h1A5);
    do_reset();

    // Strobes while deselected are ignored.
    shift_word(9'h1A5);
    for (int i = 0; i < 4; i++) op(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    op(1, 0, 0, 1, 0);
    // Update concurrent with shift decodes the pre-shift word.
    shift_word(9'h1A5);
    op(1, 0, 1, 1, 1'($urandom));
    shift_word(9'h0A5);
    op(1, 1, 1, 1, 1'($urandom));

    // Randomized traffic.
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: shift_update(pick_word());
        4:          do_reset();
        default:    op(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom));
      endcase
    end

    op(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #4;
    cmp("queue_drained", 8'(q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
